// File: rtl/morse_message_sequencer.sv
// Message-level Morse controller: buffers ASCII characters, looks up their Morse
// pattern, handshakes with the generator and inserts letter/word gaps. Define MORSE_DIGITS_EN to add digits.
module morse_message_sequencer #(
  parameter int unsigned UNIT_CYCLES = 6250000,
  parameter int unsigned BUF_DEPTH   = 16
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Char_Valid,
  input  logic [7:0] i_Char,
  output logic       o_Char_Ready,
  output logic       o_Start,
  output logic [4:0] o_Morse_Pattern,
  output logic [2:0] o_Morse_Length,
  input  logic       i_Done,
  output logic       o_Busy,
  output logic       o_Bad_Char
);

  localparam int unsigned AW = $clog2(BUF_DEPTH);
  localparam int unsigned CW = $clog2(4 * UNIT_CYCLES);
  // Generator already adds one silent unit, so a letter gap needs 2 more; a space adds 4.
  localparam logic [CW-1:0] LETTER_GAP = CW'(2 * UNIT_CYCLES - 1);
  localparam logic [CW-1:0] WORD_GAP   = CW'(4 * UNIT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [AW:0]   PTR_ONE    = (AW + 1)'(1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOOKUP,
    START,
    RELEASE,
    GAP
  } state_t;

  state_t      state;
  logic [7:0]  buf_mem [BUF_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        empty;
  logic        full;
  logic        push;
  logic        pop;
  logic [7:0]  char_q;
  logic [7:0]  char_up;
  logic [7:0]  entry;
  logic [CW-1:0] gap_cnt;

  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push         = i_Char_Valid && !full;
  assign pop          = (state == FETCH);
  assign o_Char_Ready = !full;
  assign o_Busy       = !empty || (state != IDLE);

  // {pattern, length}; length 0 marks a character with no Morse code.
  function automatic logic [7:0] morse_lookup(input logic [7:0] c);
    case (c)
      8'h41: return {5'b01000, 3'd2};
      8'h42: return {5'b10000, 3'd4};
      8'h43: return {5'b10100, 3'd4};
      8'h44: return {5'b10000, 3'd3};
      8'h45: return {5'b00000, 3'd1};
      8'h46: return {5'b00100, 3'd4};
      8'h47: return {5'b11000, 3'd3};
      8'h48: return {5'b00000, 3'd4};
      8'h49: return {5'b00000, 3'd2};
      8'h4A: return {5'b01110, 3'd4};
      8'h4B: return {5'b10100, 3'd3};
      8'h4C: return {5'b01000, 3'd4};
      8'h4D: return {5'b11000, 3'd2};
      8'h4E: return {5'b10000, 3'd2};
      8'h4F: return {5'b11100, 3'd3};
      8'h50: return {5'b01100, 3'd4};
      8'h51: return {5'b11010, 3'd4};
      8'h52: return {5'b01000, 3'd3};
      8'h53: return {5'b00000, 3'd3};
      8'h54: return {5'b10000, 3'd1};
      8'h55: return {5'b00100, 3'd3};
      8'h56: return {5'b00010, 3'd4};
      8'h57: return {5'b01100, 3'd3};
      8'h58: return {5'b10010, 3'd4};
      8'h59: return {5'b10110, 3'd4};
      8'h5A: return {5'b11000, 3'd4};
`ifdef MORSE_DIGITS_EN
      8'h30: return {5'b11111, 3'd5};
      8'h31: return {5'b01111, 3'd5};
      8'h32: return {5'b00111, 3'd5};
      8'h33: return {5'b00011, 3'd5};
      8'h34: return {5'b00001, 3'd5};
      8'h35: return {5'b00000, 3'd5};
      8'h36: return {5'b10000, 3'd5};
      8'h37: return {5'b11000, 3'd5};
      8'h38: return {5'b11100, 3'd5};
      8'h39: return {5'b11110, 3'd5};
`else
`endif
      default: return 8'h00;
    endcase
  endfunction

  always_comb begin
    char_up = char_q;
    if (char_q >= 8'h61 && char_q <= 8'h7A) char_up = char_q - 8'h20;
  end

  assign entry = morse_lookup(char_up);

  always_ff @(posedge i_Clock) begin
    if (push) buf_mem[wr_ptr[AW-1:0]] <= i_Char;
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state           <= IDLE;
      char_q          <= '0;
      gap_cnt         <= '0;
      o_Start         <= 1'b0;
      o_Morse_Pattern <= '0;
      o_Morse_Length  <= '0;
      o_Bad_Char      <= 1'b0;
    end else begin
      o_Bad_Char <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty) state <= FETCH;
        end
        FETCH: begin
          char_q <= buf_mem[rd_ptr[AW-1:0]];
          state  <= LOOKUP;
        end
        LOOKUP: begin
          if (entry[2:0] != 3'd0) begin
            o_Morse_Pattern <= entry[7:3];
            o_Morse_Length  <= entry[2:0];
            o_Start         <= !i_Done;
            state           <= START;
          end else if (char_q == 8'h20) begin
            gap_cnt <= WORD_GAP;
            state   <= GAP;
          end else begin
            o_Bad_Char <= 1'b1;
            state      <= IDLE;
          end
        end
        START: begin
          // A done left high from before a reset must clear before a new request.
          if (o_Start && i_Done) begin
            o_Start <= 1'b0;
            state   <= RELEASE;
          end else if (!i_Done) begin
            o_Start <= 1'b1;
          end
        end
        RELEASE: begin
          if (!i_Done) begin
            gap_cnt <= LETTER_GAP;
            state   <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt == '0) state <= IDLE;
          else gap_cnt <= gap_cnt - CNT_ONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_morse_message_sequencer.sv
// Directed bench for morse_message_sequencer with a behavioural Morse generator model.
module tb_morse_message_sequencer;

  localparam int U = 4;

  logic       clk;
  logic       i_Reset;
  logic       i_Char_Valid;
  logic [7:0] i_Char;
  logic       o_Char_Ready;
  logic       o_Start;
  logic [4:0] o_Morse_Pattern;
  logic [2:0] o_Morse_Length;
  logic       i_Done;
  logic       o_Busy;
  logic       o_Bad_Char;

  logic gen_en;
  logic gen_done;
  logic man_done;
  assign i_Done = gen_done | man_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic       have_off;
  int         off_cyc;
  int         done_fall_cyc;
  int         gap_q[$];
  int         start_q[$];
  logic [4:0] pat_q[$];
  logic [2:0] len_q[$];

  morse_message_sequencer #(
    .UNIT_CYCLES(U),
    .BUF_DEPTH(16)
  ) dut (
    .i_Clock(clk),
    .i_Reset(i_Reset),
    .i_Char_Valid(i_Char_Valid),
    .i_Char(i_Char),
    .o_Char_Ready(o_Char_Ready),
    .o_Start(o_Start),
    .o_Morse_Pattern(o_Morse_Pattern),
    .o_Morse_Length(o_Morse_Length),
    .i_Done(i_Done),
    .o_Busy(o_Busy),
    .o_Bad_Char(o_Bad_Char)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_code(input logic [7:0] c);
    logic [7:0] u;
    u = (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
    case (u)
      8'h41: return {5'b01000, 3'd2};
      8'h42: return {5'b10000, 3'd4};
      8'h43: return {5'b10100, 3'd4};
      8'h44: return {5'b10000, 3'd3};
      8'h45: return {5'b00000, 3'd1};
      8'h46: return {5'b00100, 3'd4};
      8'h47: return {5'b11000, 3'd3};
      8'h48: return {5'b00000, 3'd4};
      8'h49: return {5'b00000, 3'd2};
      8'h4A: return {5'b01110, 3'd4};
      8'h4B: return {5'b10100, 3'd3};
      8'h4C: return {5'b01000, 3'd4};
      8'h4D: return {5'b11000, 3'd2};
      8'h4E: return {5'b10000, 3'd2};
      8'h4F: return {5'b11100, 3'd3};
      8'h50: return {5'b01100, 3'd4};
      8'h51: return {5'b11010, 3'd4};
      8'h54: return {5'b10000, 3'd1};
      default: return 8'hFF;
    endcase
  endfunction

  // Generator: dot 1 unit, dash 3 units, 1 silent unit after every symbol, then done.
  initial begin : generator
    logic [4:0] p;
    int n;
    int w;
    gen_done = 1'b0;
    forever begin
      @(negedge clk);
      if (gen_en && o_Start && !gen_done) begin
        if (have_off) gap_q.push_back(cyc - off_cyc);
        start_q.push_back(cyc);
        p = o_Morse_Pattern;
        n = int'(o_Morse_Length);
        pat_q.push_back(o_Morse_Pattern);
        len_q.push_back(o_Morse_Length);
        for (int s = 0; s < n; s++) begin
          repeat (((s < 5 && p[4-s]) ? 3 : 1) * U) @(negedge clk);
          off_cyc = cyc;
          repeat (U) @(negedge clk);
        end
        have_off = 1'b1;
        gen_done = 1'b1;
        w = 0;
        while (o_Start && w < 100) begin
          @(negedge clk);
          w++;
        end
        check_eq("gen_release_timeout", int'(w >= 100), 0);
        gen_done = 1'b0;
        done_fall_cyc = cyc;
      end
    end
  end

  task automatic clear_log();
    gap_q.delete();
    start_q.delete();
    pat_q.delete();
    len_q.delete();
    have_off = 1'b0;
  endtask

  task automatic put_char(input logic [7:0] c, output logic acc);
    i_Char_Valid = 1'b1;
    i_Char = c;
    acc = o_Char_Ready;
    @(negedge clk);
    i_Char_Valid = 1'b0;
  endtask

  task automatic put_str(input string s);
    logic acc;
    for (int i = 0; i < s.len(); i++) put_char(s[i], acc);
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int n;
    n = 0;
    while ((o_Busy || gen_done) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, int'(n >= limit), 0);
  endtask

  task automatic check_played(input string tag, input int idx, input logic [7:0] c);
    logic [7:0] e;
    int p;
    int l;
    e = ref_code(c);
    p = -1;
    l = -1;
    if (idx < pat_q.size()) begin
      p = int'(pat_q[idx]);
      l = int'(len_q[idx]);
    end
    check_eq({tag, "_pat"}, p, int'(e[7:3]));
    check_eq({tag, "_len"}, l, int'(e[2:0]));
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog got timeout expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic acc;
    int wr;
    int n;
    int starts;
    int accepted;
    i_Reset = 1'b1;
    i_Char_Valid = 1'b0;
    i_Char = '0;
    man_done = 1'b0;
    gen_en = 1'b0;
    have_off = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_start", int'(o_Start), 0);
    check_eq("rst_pat", int'(o_Morse_Pattern), 0);
    check_eq("rst_len", int'(o_Morse_Length), 0);
    check_eq("rst_busy", int'(o_Busy), 0);
    check_eq("rst_bad", int'(o_Bad_Char), 0);
    check_eq("rst_ready", int'(o_Char_Ready), 1);
    i_Reset = 1'b0;
    @(negedge clk);

    // Single letter: latency, pattern and 2-unit trailing gap (+1 for the RELEASE cycle).
    gen_en = 1'b1;
    clear_log();
    wr = cyc;
    put_char("E", acc);
    wait_idle("e_idle_timeout", 300);
    check_eq("e_busy_fall", cyc - done_fall_cyc, 2 * U + 1);
    check_eq("e_latency", (start_q.size() > 0) ? start_q[0] - wr : -1, 4);
    check_played("e", 0, "E");

    // Letter gap: 1 trailing + 2 gap units, plus done/release round trip and IDLE/FETCH/LOOKUP.
    clear_log();
    put_str("Ka");
    wait_idle("ka_idle_timeout", 600);
    check_eq("ka_count", pat_q.size(), 2);
    check_played("k", 0, "K");
    check_played("a", 1, "a");
    check_eq("ka_gap", (gap_q.size() > 0) ? gap_q[0] : -1, 3 * U + 5);

    // Word gap: letter gap plus 4 units and one more IDLE/FETCH/LOOKUP pass for the space.
    clear_log();
    put_str("A B");
    wait_idle("ab_idle_timeout", 800);
    check_eq("ab_count", pat_q.size(), 2);
    check_played("ab_a", 0, "A");
    check_played("ab_b", 1, "B");
    check_eq("ab_gap", (gap_q.size() > 0) ? gap_q[0] : -1, 7 * U + 8);

    // Unsupported character.
    clear_log();
    starts = 0;
    put_char("#", acc);
    n = 0;
    while (!o_Bad_Char && n < 10) begin
      starts += int'(o_Start);
      @(negedge clk);
      n++;
    end
    check_eq("hash_bad_pulse", int'(o_Bad_Char), 1);
    @(negedge clk);
    check_eq("hash_pulse_width", int'(o_Bad_Char), 0);
    check_eq("hash_busy", int'(o_Busy), 0);
    check_eq("hash_no_start", starts + int'(o_Start), 0);

    // Digit.
    clear_log();
    put_char("5", acc);
`ifdef MORSE_DIGITS_EN
    wait_idle("five_idle_timeout", 600);
    check_eq("five_pat", (pat_q.size() > 0) ? int'(pat_q[0]) : -1, 0);
    check_eq("five_len", (len_q.size() > 0) ? int'(len_q[0]) : -1, 5);
`else
    n = 0;
    while (!o_Bad_Char && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_eq("five_bad_pulse", int'(o_Bad_Char), 1);
    wait_idle("five_idle_timeout", 20);
    check_eq("five_no_play", pat_q.size(), 0);
`endif

    // Overflow with the generator stalled: 1 popped + 16 buffered.
    gen_en = 1'b0;
    clear_log();
    accepted = 0;
    for (int i = 0; i < 20; i++) begin
      put_char(8'h41 + 8'(i), acc);
      accepted += int'(acc);
    end
    check_eq("full_accepted", accepted, 17);
    check_eq("full_ready", int'(o_Char_Ready), 0);
    check_eq("full_start_waiting", int'(o_Start), 1);
    gen_en = 1'b1;
    wait_idle("full_idle_timeout", 5000);
    check_eq("full_played", pat_q.size(), 17);
    for (int i = 0; i < 17; i++) check_played($sformatf("full%0d", i), i, 8'h41 + 8'(i));
    check_eq("full_ready_after", int'(o_Char_Ready), 1);

    // Reset during START with a stale done.
    gen_en = 1'b0;
    clear_log();
    put_char("T", acc);
    n = 0;
    while (!o_Start && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("rs_start_up", int'(o_Start), 1);
    man_done = 1'b1;
    i_Reset = 1'b1;
    #1;
    check_eq("rs_start_drop", int'(o_Start), 0);
    check_eq("rs_busy", int'(o_Busy), 0);
    check_eq("rs_ready", int'(o_Char_Ready), 1);
    check_eq("rs_len", int'(o_Morse_Length), 0);
    @(negedge clk);
    i_Reset = 1'b0;
    put_char("E", acc);
    starts = 0;
    repeat (12) begin
      starts += int'(o_Start);
      @(negedge clk);
    end
    check_eq("rs_stale_done_hold", starts, 0);
    man_done = 1'b0;
    @(negedge clk);
    check_eq("rs_start_after_done_low", int'(o_Start), 1);
    check_eq("rs_pat", int'(o_Morse_Pattern), 0);
    check_eq("rs_len_e", int'(o_Morse_Length), 1);
    man_done = 1'b1;
    @(negedge clk);
    check_eq("rs_release", int'(o_Start), 0);
    man_done = 1'b0;
    wait_idle("rs_idle_timeout", 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
